wb_arbiter: RTL
===============

# wb_arbiter

Write-back arbiter for the single register-file write port of the RV32I core. It merges two requesters onto the port: the in-order single-cycle datapath (A), which has fixed priority and never waits, and a multi-cycle unit such as the divider or a slow load return (B), which it buffers in a small FIFO. It drives the register-file write address, data and enable feeding the address decoder and write-enable gating. It also publishes a busy mask of pending B destinations, suppresses stale (WAW) writes and x0 writes, and stalls the core when B is starved.

## Interface
- DEPTH, 2, B-side FIFO entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive cycles a valid B head may be denied before `stall_a` asserts; ≥1
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- a_valid  in  1  core retires an instruction writing rd this cycle
- a_rd  in  5  core destination register
- a_data  in  32  core write-back data
- b_valid  in  1  B result offered
- b_ready  out  1  B result accepted this cycle when b_valid & b_ready
- b_rd  in  5  B destination register
- b_data  in  32  B result data
- rf_wr_en  out  1  register-file write strobe
- rf_rd_addr  out  5  register-file write address, to decoder
- rf_wr_data  out  32  register-file write data
- stall_a  out  1  core must freeze this cycle; a_valid ignored
- busy_mask  out  32  bit r set = live B write to xr pending

## Operation
- Clock and reset: one clock; reset is synchronous and active-low.
- FIFO: DEPTH entries of {rd, data, live}, circular read/write pointers, count 0..DEPTH.
  - `b_ready` = count < DEPTH; it is registered-state based, with no same-cycle pass-through when full.
  - On push, live = (b_rd ≠ 0) & ~kill_in. kill_in is defined below.
- A write: a_fire = a_valid & ~stall_a & (a_rd ≠ 0).
- WAW kill: when a_fire occurs, the A instruction is newer than every B result.
  - Every FIFO entry with rd == a_rd has live cleared at the edge.
  - A B result pushed in the same cycle with b_rd == a_rd is stored with live = 0 (kill_in).
- Grant, evaluated each cycle from registered state:
  - stall_a = 1 (starve counter == STARVE_LIMIT and head live): B head granted, head popped, A ignored.
  - Else if a_fire: A granted. A live head stays; a dead head (live = 0) pops in the same cycle with no write.
  - Else if the FIFO is non-empty: the head is popped. It writes only if live.
  - Else: idle.
- Write-port outputs are combinational from the grant.
  - rf_wr_en is 1 only for an A grant or a live-head grant.
  - rf_rd_addr and rf_wr_data come from the granted source, and are 0 when idle.
- rf_wr_en is never 1 with rf_rd_addr = 0.
- Starve counter:
  - Increments in any cycle where the head is live and not granted.
  - Clears on a B grant, on an empty FIFO, or on a dead head.
  - Saturates at STARVE_LIMIT.
- busy_mask: OR of one-hot(rd) over live entries, from registered state. Bit 0 is always 0.

## Timing
- Reset: FIFO empty, pointers and counter 0, all entry live bits 0.
  - Outputs during and after reset: b_ready = 0 while rst_n = 0, then 1. rf_wr_en, stall_a, busy_mask, rf_rd_addr and rf_wr_data are all 0.
- A path latency is 0 cycles: combinational inputs to rf_* in the same cycle.
- B latency: a push at edge n makes the entry visible from cycle n+1.
  - Earliest write-port grant is cycle n+1.
  - busy_mask bit set from cycle n+1 and cleared the cycle after the pop edge.
- stall_a is combinational from registered counter and head state, so it never depends on a_valid. It lasts exactly one cycle per starvation event, because the counter clears on that grant.
- Simultaneous push and pop are allowed when count < DEPTH; count is unchanged.
- Full FIFO: b_ready = 0 in that cycle even if a pop occurs.
- Pointers wrap modulo DEPTH.
- Reset mid-operation discards all entries, including live ones, and no write is issued in the reset cycle.

## Test plan
- Reset, then B pushes rd = 5, data = 0xDEAD_BEEF with A idle -> rf_wr_en = 1 with addr 5 and data 0xDEADBEEF one cycle after the push. busy_mask[5] is high for exactly that cycle.
- A writes every cycle to rd = 3 while B pushes rd = 7 -> A is always granted. stall_a pulses in the cycle after 8 denied cycles, writing B (addr 7) that cycle, then A resumes.
- B pushes rd = 9, then A writes rd = 9 before the drain -> entry killed, busy_mask[9] drops, and no rf write to x9 with B data ever occurs.
- Same cycle: B pushes rd = 4 and A writes rd = 4 -> A's write lands and the B entry later pops with rf_wr_en = 0.
- Fill the FIFO (2 pushes, A busy) -> b_ready = 0, and the third offer is held until a pop, then accepted. B rd = 0 pushes produce no write. A a_rd = 0 with A valid lets a live head drain that cycle.
- Assert rst_n = 0 with 2 live entries -> next cycle count 0, busy_mask 0, and no rf write.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the core, the multi-cycle unit (B) and the
// register-file write port served by wb_arbiter.
interface wb_arbiter_if;
  // Requester A: in-order single-cycle datapath
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  // Requester B: multi-cycle unit / slow load return
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_rd;
  logic [31:0] b_data;
  // Register-file write port
  logic        rf_wr_en;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_wr_data;
  // Core control / hazard information
  logic        stall_a;
  logic [31:0] busy_mask;

  // Arbiter side
  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output rf_wr_en, rf_rd_addr, rf_wr_data,
    output stall_a, busy_mask
  );

  // Requester / environment side
  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  rf_wr_en, rf_rd_addr, rf_wr_data,
    input  stall_a, busy_mask
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single RV32I register-file write port.
// A (core) has fixed priority and never waits; B results are buffered in a
// small FIFO, tracked in busy_mask, killed when a newer A write to the same
// rd retires (WAW), and forced through with a one-cycle stall_a when the
// head has been starved for STARVE_LIMIT cycles.
module wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // FIFO storage and bookkeeping
  logic [4:0]    rd_q   [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  // Decoded control
  logic          head_valid_s;
  logic          head_live_s;
  logic          stall_s;
  logic          a_fire_s;
  logic          b_ready_s;
  logic          push_s;
  logic          pop_s;
  logic          kill_in_s;
  grant_e        grant_s;
  logic          wr_en_s;
  logic [4:0]    wr_addr_s;
  logic [31:0]   wr_data_s;
  logic [31:0]   busy_mask_s;

  // Head status, starvation stall and A fire, all from registered state
  always_comb begin
    head_valid_s = (count_q != {CW{1'b0}});
    head_live_s  = head_valid_s & live_q[rd_ptr_q];
    stall_s      = rst_n & head_live_s & (starve_q == LIMIT_C);
    a_fire_s     = rst_n & bus.a_valid & ~stall_s & (bus.a_rd != 5'd0);
    b_ready_s    = rst_n & (count_q < DEPTH_C);
    push_s       = bus.b_valid & b_ready_s;
    kill_in_s    = a_fire_s & (bus.b_rd == bus.a_rd);
  end

  // Grant selection and head pop decision
  always_comb begin
    grant_s = GNT_IDLE;
    pop_s   = 1'b0;
    if (!rst_n) begin
      grant_s = GNT_IDLE;
      pop_s   = 1'b0;
    end else if (stall_s) begin
      grant_s = GNT_B;
      pop_s   = 1'b1;
    end else if (a_fire_s) begin
      // a dead head is discarded underneath the A write
      grant_s = GNT_A;
      pop_s   = head_valid_s & ~head_live_s;
    end else if (head_valid_s) begin
      grant_s = head_live_s ? GNT_B : GNT_IDLE;
      pop_s   = 1'b1;
    end else begin
      grant_s = GNT_IDLE;
      pop_s   = 1'b0;
    end
  end

  // Write-port mux driven by the grant
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = 5'd0;
    wr_data_s = 32'd0;
    case (grant_s)
      GNT_A: begin
        wr_en_s   = 1'b1;
        wr_addr_s = bus.a_rd;
        wr_data_s = bus.a_data;
      end
      GNT_B: begin
        wr_en_s   = 1'b1;
        wr_addr_s = rd_q[rd_ptr_q];
        wr_data_s = data_q[rd_ptr_q];
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = 5'd0;
        wr_data_s = 32'd0;
      end
    endcase
  end

  // Next live bits: WAW kill, clear on pop, set on push
  always_comb begin
    live_d = live_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (a_fire_s && (rd_q[i] == bus.a_rd)) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_d[i];
      end
      if (pop_s && (rd_ptr_q == AW'(i))) begin
        live_d[i] = 1'b0;
      end else begin
        live_d[i] = live_d[i];
      end
      // the write slot is always free when a push is accepted
      if (push_s && (wr_ptr_q == AW'(i))) begin
        live_d[i] = (bus.b_rd != 5'd0) & ~kill_in_s;
      end else begin
        live_d[i] = live_d[i];
      end
    end
  end

  // Pointer and occupancy next state; pointers wrap modulo DEPTH
  always_comb begin
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Starve counter: counts only while a live head is passed over by A
  always_comb begin
    starve_d = {SW{1'b0}};
    if (head_live_s && a_fire_s) begin
      if (starve_q == LIMIT_C) begin
        starve_d = starve_q;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end else begin
      starve_d = {SW{1'b0}};
    end
  end

  // Pending-destination mask over live entries; x0 is never busy
  always_comb begin
    busy_mask_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) begin
        busy_mask_s[rd_q[i]] = 1'b1;
      end else begin
        busy_mask_s = busy_mask_s;
      end
    end
    busy_mask_s[0] = 1'b0;
    if (!rst_n) begin
      busy_mask_s = 32'd0;
    end else begin
      busy_mask_s = busy_mask_s;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q   <= {DEPTH{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      wr_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      starve_q <= {SW{1'b0}};
    end else begin
      live_q   <= live_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO payload storage, written on accepted B pushes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= 5'd0;
        data_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      rd_q[wr_ptr_q]   <= bus.b_rd;
      data_q[wr_ptr_q] <= bus.b_data;
    end
  end

  assign bus.b_ready    = b_ready_s;
  assign bus.stall_a    = stall_s;
  assign bus.rf_wr_en   = wr_en_s;
  assign bus.rf_rd_addr = wr_addr_s;
  assign bus.rf_wr_data = wr_data_s;
  assign bus.busy_mask  = busy_mask_s;

endmodule
